// File: rtl/mc_ctrl_pkg.sv
// Shared encodings and the per-state control decode for the multi-cycle MIPS controller.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SUBI  = 6'b001001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [3:0] {
    S_FETCH_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I,
    S_WB_I, S_MEM_ADDR, S_MEM_WR, S_BRANCH, S_TRAP
  } state_e;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_CMP = 2'b01, ALU_FUNCT = 2'b10, ALU_SUB = 2'b11} aluop_e;
  typedef enum logic [1:0] {SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11} srcb_e;
  typedef enum logic [1:0] {PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01} pcsrc_e;

  typedef struct packed {
    logic   mem_req;
    logic   mem_read;
    logic   mem_write;
    logic   iord;
    logic   pc_write_cond;
    pcsrc_e pc_source;
    logic   alu_src_a;
    srcb_e  alu_src_b;
    aluop_e alu_op;
    logic   reg_dst;
    logic   reg_write;
    logic   done;
  } ctrl_t;

  // Pure Moore decode; the mem_ready-qualified strobes are added in the top.
  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req = 1'b1; c.mem_read = 1'b1; c.alu_src_b = SRCB_FOUR;
      end
      S_DECODE:   c.alu_src_b = SRCB_IMM_SH2;
      S_EXEC_R: begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_RT; c.alu_op = ALU_FUNCT;
      end
      S_WB_R: begin
        c.reg_dst = 1'b1; c.reg_write = 1'b1; c.done = 1'b1;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_SUB;
      end
      S_WB_I: begin
        c.reg_write = 1'b1; c.done = 1'b1;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM;
      end
      S_MEM_WR: begin
        c.mem_req = 1'b1; c.mem_write = 1'b1; c.iord = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_RT; c.alu_op = ALU_CMP;
        c.pc_write_cond = 1'b1; c.pc_source = PCS_ALUOUT; c.done = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles an outstanding memory request goes unanswered and flags the timeout.
module mem_wait_timer #(
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_req_i,
  input  logic mem_ready_i,
  output logic timeout_o
);

  localparam logic [TMO_W-1:0] CNT_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             waiting;

  assign waiting = mem_req_i & ~mem_ready_i;

  always_comb begin
    cnt_d = '0;
    if (waiting) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TMO_W'(1);
  end

  // Fires on the wait cycle whose edge would bring the count to MEM_TIMEOUT.
  assign timeout_o = (MEM_TIMEOUT != 0) && waiting && (cnt_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencing FSM (OR, SUBI, SW, BEQ) over a shared memory port.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       halt,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   illegal_q, illegal_d, bus_err_q, bus_err_d;
  logic   timeout;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_FETCH_IDLE: if (!halt) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) begin state_d = S_TRAP; bus_err_d = 1'b1; end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: state_d = S_EXEC_R;
          OP_SUBI:  state_d = S_EXEC_I;
          OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ:   state_d = S_BRANCH;
          default:  begin state_d = S_TRAP; illegal_d = 1'b1; end
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = S_MEM_WR;
      S_MEM_WR: begin
        if (mem_ready)    state_d = S_FETCH_IDLE;
        else if (timeout) begin state_d = S_TRAP; bus_err_d = 1'b1; end
      end
      S_WB_R, S_WB_I, S_BRANCH: state_d = S_FETCH_IDLE;
      default: ;
    endcase
  end

  // Outputs are registered from the next state, so they track state_q exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH_IDLE;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= decode(state_d);
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  mem_wait_timer #(.TMO_W(TMO_W), .MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req_i  (ctrl_q.mem_req),
    .mem_ready_i(mem_ready),
    .timeout_o  (timeout)
  );

  assign mem_req     = ctrl_q.mem_req;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign IorD        = ctrl_q.iord;
  assign IRWrite     = (state_q == S_FETCH) && mem_ready;
  assign PCWrite     = (state_q == S_FETCH) && mem_ready;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign PCSource    = ctrl_q.pc_source;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign ALUOp       = ctrl_q.alu_op;
  assign RegDst      = ctrl_q.reg_dst;
  assign RegWrite    = ctrl_q.reg_write;
  assign MemToReg    = 1'b0;
  assign instr_done  = ctrl_q.done | ((state_q == S_MEM_WR) && mem_ready);
  assign illegal     = illegal_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed cycle-by-cycle check of the multi-cycle controller against per-state expected outputs.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       halt = 1'b1;
  logic       mem_ready = 1'b0;
  logic       mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic       ALUSrcA, RegDst, RegWrite, MemToReg, instr_done, illegal, bus_err;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TMO_W(8), .MEM_TIMEOUT(5)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .halt(halt), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .instr_done(instr_done),
    .illegal(illegal), .bus_err(bus_err)
  );

  // {mem_req,MemRead,MemWrite,IorD,IRWrite,PCWrite,PCWriteCond,PCSource,ALUSrcA,ALUSrcB,ALUOp,
  //  RegDst,RegWrite,MemToReg,instr_done,illegal,bus_err}
  localparam logic [19:0] E_IDLE  = 20'b0_0_0_0_0_0_0_00_0_00_00_0_0_0_0_0_0;
  localparam logic [19:0] E_FW    = 20'b1_1_0_0_0_0_0_00_0_01_00_0_0_0_0_0_0;
  localparam logic [19:0] E_FR    = 20'b1_1_0_0_1_1_0_00_0_01_00_0_0_0_0_0_0;
  localparam logic [19:0] E_DEC   = 20'b0_0_0_0_0_0_0_00_0_11_00_0_0_0_0_0_0;
  localparam logic [19:0] E_EXR   = 20'b0_0_0_0_0_0_0_00_1_00_10_0_0_0_0_0_0;
  localparam logic [19:0] E_WBR   = 20'b0_0_0_0_0_0_0_00_0_00_00_1_1_0_1_0_0;
  localparam logic [19:0] E_EXI   = 20'b0_0_0_0_0_0_0_00_1_10_11_0_0_0_0_0_0;
  localparam logic [19:0] E_WBI   = 20'b0_0_0_0_0_0_0_00_0_00_00_0_1_0_1_0_0;
  localparam logic [19:0] E_MADR  = 20'b0_0_0_0_0_0_0_00_1_10_00_0_0_0_0_0_0;
  localparam logic [19:0] E_MWW   = 20'b1_0_1_1_0_0_0_00_0_00_00_0_0_0_0_0_0;
  localparam logic [19:0] E_MWR   = 20'b1_0_1_1_0_0_0_00_0_00_00_0_0_0_1_0_0;
  localparam logic [19:0] E_BR    = 20'b0_0_0_0_0_0_1_01_1_00_01_0_0_0_1_0_0;
  localparam logic [19:0] E_TILL  = 20'b0_0_0_0_0_0_0_00_0_00_00_0_0_0_0_1_0;
  localparam logic [19:0] E_TBUS  = 20'b0_0_0_0_0_0_0_00_0_00_00_0_0_0_0_0_1;

  typedef struct {
    logic [19:0] exp;
    string       tag;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk = 0;
  int  n_pass = 0;

  function automatic logic [19:0] observe();
    return {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource,
            ALUSrcA, ALUSrcB, ALUOp, RegDst, RegWrite, MemToReg, instr_done, illegal, bus_err};
  endfunction

  task automatic compare_front();
    sb_t         e;
    logic [19:0] obs;
    e   = sb_q.pop_front();
    obs = observe();
    n_chk++;
    assert (obs === e.exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the falling edge.
  task automatic cyc(input logic [19:0] exp, input string tag);
    sb_q.push_back('{exp, tag});
    @(negedge clk);
    compare_front();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_now(input logic [19:0] exp, input string tag);
    sb_q.push_back('{exp, tag});
    #1;
    compare_front();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    chk_now(E_IDLE, "reset_now");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_now(E_IDLE, "reset");
    rst_n = 1'b1;

    // halted idle ignores mem_ready
    halt = 1'b1; mem_ready = 1'b1;
    cyc(E_IDLE, "halt_idle0");
    cyc(E_IDLE, "halt_idle1");

    // OR, ready immediately
    halt = 1'b0; opcode = 6'b000000;
    cyc(E_IDLE, "or_idle");
    cyc(E_FR,   "or_fetch");
    cyc(E_DEC,  "or_decode");
    cyc(E_EXR,  "or_exec");
    cyc(E_WBR,  "or_wb");

    // SW with three wait cycles on the write
    opcode = 6'b101011;
    cyc(E_IDLE, "sw_idle");
    cyc(E_FR,   "sw_fetch");
    cyc(E_DEC,  "sw_decode");
    cyc(E_MADR, "sw_addr");
    mem_ready = 1'b0;
    cyc(E_MWW,  "sw_wait1");
    cyc(E_MWW,  "sw_wait2");
    cyc(E_MWW,  "sw_wait3");
    mem_ready = 1'b1;
    cyc(E_MWR,  "sw_ready");

    // BEQ
    opcode = 6'b000100;
    cyc(E_IDLE, "beq_idle");
    cyc(E_FR,   "beq_fetch");
    cyc(E_DEC,  "beq_decode");
    cyc(E_BR,   "beq_branch");

    // SUBI with halt raised mid-instruction
    opcode = 6'b001001;
    cyc(E_IDLE, "subi_idle");
    cyc(E_FR,   "subi_fetch");
    cyc(E_DEC,  "subi_decode");
    halt = 1'b1;
    cyc(E_EXI,  "subi_exec");
    cyc(E_WBI,  "subi_wb");
    cyc(E_IDLE, "subi_halt0");
    cyc(E_IDLE, "subi_halt1");
    halt = 1'b0;
    cyc(E_IDLE, "unhalt_idle");

    // fetch with two wait cycles, then OR, reset during EXEC_R
    mem_ready = 1'b0; opcode = 6'b000000;
    cyc(E_FW,   "fw_wait1");
    cyc(E_FW,   "fw_wait2");
    mem_ready = 1'b1;
    cyc(E_FR,   "fw_ready");
    cyc(E_DEC,  "mid_decode");
    do_reset();

    // unsupported LW
    opcode = 6'b100011;
    cyc(E_IDLE, "lw_idle");
    cyc(E_FR,   "lw_fetch");
    cyc(E_DEC,  "lw_decode");
    cyc(E_TILL, "lw_trap0");
    mem_ready = 1'b0;
    cyc(E_TILL, "lw_trap1");
    do_reset();
    mem_ready = 1'b1;
    cyc(E_IDLE, "lw_cleared");

    // fetch timeout
    mem_ready = 1'b0;
    cyc(E_FW,   "tmo_w1");
    cyc(E_FW,   "tmo_w2");
    cyc(E_FW,   "tmo_w3");
    cyc(E_FW,   "tmo_w4");
    cyc(E_FW,   "tmo_w5");
    cyc(E_TBUS, "tmo_trap0");
    mem_ready = 1'b1;
    cyc(E_TBUS, "tmo_trap1");
    do_reset();

    // ready on the timeout cycle wins
    mem_ready = 1'b0; opcode = 6'b000000;
    cyc(E_IDLE, "race_idle");
    cyc(E_FW,   "race_w1");
    cyc(E_FW,   "race_w2");
    cyc(E_FW,   "race_w3");
    cyc(E_FW,   "race_w4");
    mem_ready = 1'b1;
    cyc(E_FR,   "race_ready");
    cyc(E_DEC,  "race_decode");
    cyc(E_EXR,  "race_exec");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
